// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writers in EX/MEM/WB and drives operand forwarding selects and ID stall
module hazard_scoreboard #(
    parameter bit FWD_EN       = 1'b1,
    parameter bit LOAD_FWD_MEM = 1'b0,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1_used,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_dest,
    input  logic             id_gr_we,
    input  logic             id_is_load,
    input  logic             ex_allow_in,
    input  logic             ex_go,
    input  logic             mem_go,
    input  logic             wb_go,
    input  logic             flush,
    output logic             id_stall,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt
);
    logic       ex_v, mem_v, wb_v;
    logic [4:0] ex_d, mem_d, wb_d;
    logic       ex_l, mem_l;
    logic       stall1, stall2, id_fire;

    // Returns {stall, sel} for one source; the youngest matching writer decides both.
    function automatic logic [2:0] resolve(input logic used, input logic [4:0] r);
        logic       m_ex, m_mem, m_wb, st;
        logic [1:0] sel;
        m_ex  = used && r != 5'd0 && ex_v && ex_d == r;
        m_mem = used && r != 5'd0 && mem_v && mem_d == r;
        m_wb  = used && r != 5'd0 && wb_v && wb_d == r;
        sel   = m_ex ? 2'd1 : m_mem ? 2'd2 : m_wb ? 2'd3 : 2'd0;
        st    = FWD_EN ? ((m_ex && ex_l) || (!m_ex && m_mem && mem_l && !LOAD_FWD_MEM))
                       : (m_ex || m_mem || m_wb);
        return {st, sel};
    endfunction

    // Resolve both source operands against the current shadow pipeline.
    always_comb begin
        {stall1, fwd_sel1} = resolve(id_rs1_used, id_rs1);
        {stall2, fwd_sel2} = resolve(id_rs2_used, id_rs2);
    end

    assign id_stall = id_valid && (stall1 || stall2);
    assign id_fire  = id_valid && !id_stall && ex_allow_in;

    // EX slot: a new fire overrides a same-cycle departure; flush kills everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_v <= 1'b0;
            ex_d <= 5'd0;
            ex_l <= 1'b0;
        end else if (flush) begin
            ex_v <= 1'b0;
        end else if (id_fire) begin
            ex_v <= id_gr_we && id_dest != 5'd0;
            ex_d <= id_dest;
            ex_l <= id_is_load;
        end else if (ex_go) begin
            ex_v <= 1'b0;
        end
    end

    // MEM slot follows EX on ex_go and empties on mem_go unless refilled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_v <= 1'b0;
            mem_d <= 5'd0;
            mem_l <= 1'b0;
        end else if (flush) begin
            mem_v <= 1'b0;
        end else if (ex_go) begin
            mem_v <= ex_v;
            mem_d <= ex_d;
            mem_l <= ex_l;
        end else if (mem_go) begin
            mem_v <= 1'b0;
        end
    end

    // WB slot is past the point of no return, so flush leaves it alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_v <= 1'b0;
            wb_d <= 5'd0;
        end else if (mem_go) begin
            wb_v <= mem_v;
            wb_d <= mem_d;
        end else if (wb_go) begin
            wb_v <= 1'b0;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stall_cnt <= '0;
        else if (id_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of a forwarding and an interlock-only scoreboard against a behavioural model
module tb_hazard_scoreboard;
    logic clk = 1'b0, resetn = 1'b1;
    logic id_valid, id_rs1_used, id_rs2_used, id_gr_we, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_dest;
    logic ex_allow_in, ex_go, mem_go, wb_go, flush;
    logic st0, st1;
    logic [1:0] a0, b0, a1, b1;
    logic [31:0] c0;
    logic [2:0] c1;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut0 (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_dest(id_dest), .id_gr_we(id_gr_we),
        .id_is_load(id_is_load), .ex_allow_in(ex_allow_in), .ex_go(ex_go), .mem_go(mem_go),
        .wb_go(wb_go), .flush(flush), .id_stall(st0), .fwd_sel1(a0), .fwd_sel2(b0), .stall_cnt(c0)
    );

    hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(3)) dut1 (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_dest(id_dest), .id_gr_we(id_gr_we),
        .id_is_load(id_is_load), .ex_allow_in(ex_allow_in), .ex_go(ex_go), .mem_go(mem_go),
        .wb_go(wb_go), .flush(flush), .id_stall(st1), .fwd_sel1(a1), .fwd_sel2(b1), .stall_cnt(c1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = youngest (EX), 2 = oldest (WB); w=0 forwarding DUT, w=1 interlock DUT.
    logic        mv[2][3];
    logic [4:0]  md[2][3];
    logic        ml[2][3];
    logic [63:0] mcnt[2];

    function automatic logic [63:0] cmax(input int w);
        return w == 0 ? 64'hFFFF_FFFF : 64'd7;
    endfunction

    function automatic void resolve(input int w, input logic used, input logic [4:0] r,
                                    output logic [1:0] sel, output logic st);
        int hit, nm;
        hit = -1;
        nm = 0;
        if (used && r != 5'd0)
            for (int k = 0; k < 3; k++)
                if (mv[w][k] && md[w][k] == r) begin
                    nm++;
                    if (hit < 0) hit = k;
                end
        sel = hit < 0 ? 2'd0 : 2'(hit + 1);
        st = (w == 1) ? (nm > 0) : ((hit == 0 && ml[w][0]) || (hit == 1 && ml[w][1]));
    endfunction

    function automatic logic exp_stall(input int w);
        logic [1:0] x;
        logic s1, s2;
        resolve(w, id_rs1_used, id_rs1, x, s1);
        resolve(w, id_rs2_used, id_rs2, x, s2);
        return id_valid && (s1 || s2);
    endfunction

    always @(posedge clk or negedge resetn) begin
        for (int w = 0; w < 2; w++) begin
            if (!resetn) begin
                for (int k = 0; k < 3; k++) begin
                    mv[w][k] = 1'b0;
                    md[w][k] = 5'd0;
                    ml[w][k] = 1'b0;
                end
                mcnt[w] = 64'd0;
            end else begin
                logic s, f;
                s = exp_stall(w);
                f = id_valid && !s && ex_allow_in;
                if (s && mcnt[w] < cmax(w)) mcnt[w]++;
                if (mem_go) begin
                    mv[w][2] = mv[w][1]; md[w][2] = md[w][1]; ml[w][2] = ml[w][1];
                end else if (wb_go) mv[w][2] = 1'b0;
                if (flush) mv[w][1] = 1'b0;
                else if (ex_go) begin
                    mv[w][1] = mv[w][0]; md[w][1] = md[w][0]; ml[w][1] = ml[w][0];
                end else if (mem_go) mv[w][1] = 1'b0;
                if (flush) mv[w][0] = 1'b0;
                else if (f) begin
                    mv[w][0] = id_gr_we && id_dest != 5'd0; md[w][0] = id_dest; ml[w][0] = id_is_load;
                end else if (ex_go) mv[w][0] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e1, e2;
        logic x1, x2;
        resolve(0, id_rs1_used, id_rs1, e1, x1);
        resolve(0, id_rs2_used, id_rs2, e2, x2);
        check("m_sel1_fwd", a0, e1);
        check("m_sel2_fwd", b0, e2);
        check("m_stall_fwd", st0, exp_stall(0));
        check("m_cnt_fwd", c0, mcnt[0]);
        resolve(1, id_rs1_used, id_rs1, e1, x1);
        resolve(1, id_rs2_used, id_rs2, e2, x2);
        check("m_sel1_il", a1, e1);
        check("m_sel2_il", b1, e2);
        check("m_stall_il", st1, exp_stall(1));
        check("m_cnt_il", c1, mcnt[1]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] d, input logic we, input logic ld);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_dest = d; id_gr_we = we; id_is_load = ld;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        {ex_allow_in, ex_go, mem_go, wb_go, flush} = '0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        {ex_allow_in, ex_go, mem_go, wb_go} = 4'hF;
    endtask

    initial begin
        #1;
        do_reset();
        #1;
        check("reset_stall", st0, 0); check("reset_sel1", a0, 0); check("reset_cnt", c0, 0);
        // add r3 in EX, ID reads r3
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        tick(); set_id(1, 3, 1, 0, 0, 0, 0, 0); #1;
        check("t1_sel1", a0, 1); check("t1_stall", st0, 0);
        check("t1_il_stall", st1, 1); check("t1_il_sel1", a1, 1);
        tick(); #1; check("t1_mem_sel1", a0, 2); check("t1_il_stall_mem", st1, 1);
        tick(); #1; check("t1_wb_sel1", a0, 3); check("t1_il_stall_wb", st1, 1);
        tick(); #1; check("t1_done_sel1", a0, 0); check("t1_il_free", st1, 0); check("t1_il_cnt", c1, 3);
        // load-use
        do_reset(); set_id(1, 0, 0, 0, 0, 4, 1, 1);
        tick(); set_id(1, 0, 0, 4, 1, 0, 0, 0); #1;
        check("t2_ex_stall", st0, 1); check("t2_ex_sel2", b0, 1); check("t2_ex_cnt", c0, 0);
        tick(); #1; check("t2_mem_stall", st0, 1); check("t2_mem_sel2", b0, 2); check("t2_mem_cnt", c0, 1);
        tick(); #1; check("t2_wb_stall", st0, 0); check("t2_wb_sel2", b0, 3); check("t2_wb_cnt", c0, 2);
        // r0 destination never creates a writer
        do_reset(); set_id(1, 0, 0, 0, 0, 0, 1, 0);
        tick(); set_id(1, 0, 1, 0, 1, 0, 0, 0); #1;
        check("t3_sel1", a0, 0); check("t3_sel2", b0, 0); check("t3_stall", st0, 0); check("t3_il_stall", st1, 0);
        // add r5 in EX shadows load r5 in MEM
        do_reset(); set_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick(); set_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick(); set_id(1, 5, 1, 5, 1, 0, 0, 0); #1;
        check("t4_sel1", a0, 1); check("t4_sel2", b0, 1); check("t4_stall", st0, 0); check("t4_il_stall", st1, 1);
        // flush with a same-cycle fire
        do_reset(); set_id(1, 0, 0, 0, 0, 6, 1, 0);
        tick(); set_id(1, 0, 0, 0, 0, 7, 1, 0);
        tick(); set_id(1, 0, 0, 0, 0, 8, 1, 0); flush = 1'b1;
        tick(); flush = 1'b0; set_id(1, 6, 1, 8, 1, 0, 0, 0); #1;
        check("t5_wb_sel1", a0, 3); check("t5_ex_sel2", b0, 0); check("t5_stall", st0, 0); check("t5_il_stall", st1, 1);
        tick(); set_id(1, 6, 1, 7, 1, 0, 0, 0); #1;
        check("t5_ret_sel1", a0, 0); check("t5_mem_sel2", b0, 0); check("t5_il_free", st1, 0);
        // async reset in the middle of a load-use stall
        do_reset(); set_id(1, 0, 0, 0, 0, 4, 1, 1);
        tick(); set_id(1, 0, 0, 4, 1, 0, 0, 0);
        tick(); #1; check("t6_pre_stall", st0, 1); check("t6_pre_cnt", c0, 1);
        resetn = 1'b0; #1;
        check("t6_stall", st0, 0); check("t6_sel2", b0, 0); check("t6_cnt", c0, 0); check("t6_il_cnt", c1, 0);
        // EX held by ex_allow_in/ex_go low
        do_reset(); set_id(1, 0, 0, 0, 0, 9, 1, 0);
        tick(); ex_allow_in = 1'b0; ex_go = 1'b0; set_id(1, 9, 1, 0, 0, 0, 0, 0); #1;
        check("t7_sel1", a0, 1); check("t7_stall", st0, 0);
        tick(); #1; check("t7_hold_sel1", a0, 1); check("t7_il_hold", st1, 1);
        ex_allow_in = 1'b1; ex_go = 1'b1;
        // WB held, interlock counter saturates
        do_reset(); set_id(1, 0, 0, 0, 0, 10, 1, 0);
        tick(); wb_go = 1'b0; set_id(1, 10, 1, 0, 0, 0, 0, 0);
        tick(); tick(); mem_go = 1'b0;
        repeat (8) tick();
        #1; check("t8_il_sat", c1, 7); check("t8_il_stall", st1, 1); check("t8_sel1", a0, 3); check("t8_stall", st0, 0);
        mem_go = 1'b1; wb_go = 1'b1;
        tick(); #1; check("t8_ret_sel1", a0, 0); check("t8_il_free", st1, 0); check("t8_il_cnt", c1, 7);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
